eaf_bloom: RTL and testbench

EAF_BLOOM -- requirements
Module: eaf_bloom

---
 rtl/eaf_bloom.sv | 117 +++++++++++
 tb/tb_eaf_bloom.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/eaf_bloom.sv
// eaf_bloom: evicted-address Bloom filter with insert-count triggered and external flush
module eaf_bloom #(
   parameter int ADDR_W      = 32,
   parameter int TAG_LSB     = 6,
   parameter int FILTER_BITS = 1024,
   parameter int NUM_HASH    = 2,
   parameter int MAX_INSERT  = FILTER_BITS / 8,
   parameter int CLR_W       = 64
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          req_valid,
   output logic                          req_ready,
   input  logic                          req_op,
   input  logic [ADDR_W-1:0]             req_addr,
   input  logic                          clr_i,
   output logic                          resp_valid,
   output logic                          resp_present,
   output logic                          resp_priority,
   output logic [$clog2(MAX_INSERT):0]   insert_count,
   output logic                          busy
);
   localparam int IDX_W = $clog2(FILTER_BITS);
   localparam int BW    = ADDR_W - TAG_LSB;
   localparam int NCH   = (BW + IDX_W - 1) / IDX_W;
   localparam int NCLR  = FILTER_BITS / CLR_W;
   localparam int CNT_W = (NCLR > 1) ? $clog2(NCLR) : 1;
   localparam int IC_W  = $clog2(MAX_INSERT) + 1;

   typedef enum logic {IDLE, CLEAR} state_t;

   state_t                 state_q, state_d;
   logic [FILTER_BITS-1:0] filter_q, filter_d;
   logic [IC_W-1:0]        count_q, count_d;
   logic [CNT_W-1:0]       chunk_q, chunk_d;
   logic                   pend_q, pend_d;
   logic                   resp_valid_q, resp_valid_d;
   logic                   resp_present_q, resp_present_d;
   logic [BW-1:0]          blk;
   logic [2*BW-1:0]        dbl;
   logic [NCH*IDX_W-1:0]   pad [NUM_HASH];
   logic [IDX_W-1:0]       h_idx [NUM_HASH];
   logic                   accept;
   logic                   hit;

   assign req_ready     = (state_q == IDLE) && !clr_i && !pend_q;
   assign accept        = req_valid && req_ready;
   assign busy          = (state_q == CLEAR);
   assign resp_valid    = resp_valid_q;
   assign resp_present  = resp_present_q;
   assign resp_priority = resp_present_q;
   assign insert_count  = count_q;

   // hash k: block rotated left by 3k (window of the doubled block), zero-padded and XOR-folded
   always_comb begin
      blk = req_addr[ADDR_W-1:TAG_LSB];
      dbl = {blk, blk};
      for (int k = 0; k < NUM_HASH; k++) begin
         pad[k] = '0;
         pad[k][BW-1:0] = dbl[BW - ((3 * k) % BW) +: BW];
         h_idx[k] = '0;
         for (int c = 0; c < NCH; c++) h_idx[k] = h_idx[k] ^ pad[k][c*IDX_W +: IDX_W];
      end
   end

   // next state: lookup/insert while idle, chunked zeroing while clearing
   always_comb begin
      state_d        = state_q;
      filter_d       = filter_q;
      count_d        = count_q;
      chunk_d        = chunk_q;
      pend_d         = pend_q;
      hit            = 1'b1;
      for (int k = 0; k < NUM_HASH; k++) hit = hit & filter_q[h_idx[k]];
      resp_valid_d   = accept;
      resp_present_d = accept ? hit : resp_present_q;
      if (state_q == IDLE) begin
         if (clr_i || pend_q) begin
            state_d = CLEAR;
            chunk_d = '0;
         end else if (accept && req_op) begin
            for (int k = 0; k < NUM_HASH; k++) filter_d[h_idx[k]] = 1'b1;
            count_d = count_q + 1'b1;
            pend_d  = (count_d == IC_W'(MAX_INSERT));
         end
      end else begin
         filter_d[chunk_q*CLR_W +: CLR_W] = '0;
         chunk_d = chunk_q + 1'b1;
         if (chunk_q == CNT_W'(NCLR - 1)) begin
            state_d = IDLE;
            count_d = '0;
            pend_d  = 1'b0;
         end
      end
   end

   // state registers; reset aborts any clear or response in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= IDLE;
         filter_q       <= '0;
         count_q        <= '0;
         chunk_q        <= '0;
         pend_q         <= 1'b0;
         resp_valid_q   <= 1'b0;
         resp_present_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         filter_q       <= filter_d;
         count_q        <= count_d;
         chunk_q        <= chunk_d;
         pend_q         <= pend_d;
         resp_valid_q   <= resp_valid_d;
         resp_present_q <= resp_present_d;
      end
   end
endmodule

// File: tb/tb_eaf_bloom.sv
// tb_eaf_bloom: directed checks of lookup, insert, auto/external clear and async reset
module tb_eaf_bloom;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_op = 1'b0;
   logic [31:0] req_addr = '0;
   logic        clr_i = 1'b0;
   logic        req_ready, resp_valid, resp_present, resp_priority, busy;
   logic [2:0]  insert_count;
   int          n_run = 0;
   int          n_fail = 0;

   always #5 clk = ~clk;

   eaf_bloom #(
      .ADDR_W(32), .TAG_LSB(6), .FILTER_BITS(64), .NUM_HASH(2), .MAX_INSERT(4), .CLR_W(16)
   ) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_op(req_op), .req_addr(req_addr), .clr_i(clr_i), .resp_valid(resp_valid),
      .resp_present(resp_present), .resp_priority(resp_priority),
      .insert_count(insert_count), .busy(busy)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic do_reset;
      rst_n = 1'b0;
      req_valid = 1'b0;
      clr_i = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic issue(input logic op, input logic [31:0] addr);
      req_valid = 1'b1;
      req_op = op;
      req_addr = addr;
      @(posedge clk);
      #1 req_valid = 1'b0;
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   initial begin
      do_reset;
      check("rst_resp_valid", resp_valid, 0);
      check("rst_present", resp_present, 0);
      check("rst_busy", busy, 0);
      check("rst_count", insert_count, 0);
      check("rst_ready", req_ready, 1);
      issue(0, 32'h40);
      check("t40_valid", resp_valid, 1);
      check("t40_present", resp_present, 0);
      check("t40_prio", resp_priority, 0);
      step;
      check("t40_pulse_end", resp_valid, 0);

      do_reset;
      issue(1, 32'h1000);
      check("i1000_valid", resp_valid, 1);
      check("i1000_present", resp_present, 0);
      check("i1000_count", insert_count, 1);
      issue(0, 32'h1000);
      check("t1000_valid", resp_valid, 1);
      check("t1000_present", resp_present, 1);
      check("t1000_prio", resp_priority, 1);
      step;
      check("hold_valid", resp_valid, 0);
      check("hold_present", resp_present, 1);

      do_reset;
      issue(1, 32'h2000);
      check("i2000a_present", resp_present, 0);
      issue(1, 32'h2000);
      check("i2000b_present", resp_present, 1);
      check("i2000b_count", insert_count, 2);

      do_reset;
      issue(1, 32'h1000);
      issue(1, 32'h2000);
      issue(1, 32'h4000);
      check("auto_ready_pre", req_ready, 1);
      issue(1, 32'h8000);
      check("auto_4th_valid", resp_valid, 1);
      check("auto_4th_present", resp_present, 1);
      check("auto_4th_count", insert_count, 4);
      check("auto_4th_busy", busy, 0);
      check("auto_4th_ready", req_ready, 0);
      for (int i = 0; i < 4; i++) begin
         step;
         check("auto_busy", busy, 1);
         check("auto_ready_low", req_ready, 0);
      end
      step;
      check("auto_busy_end", busy, 0);
      check("auto_ready_back", req_ready, 1);
      check("auto_count_zero", insert_count, 0);
      issue(0, 32'h1000);
      check("auto_cleared_valid", resp_valid, 1);
      check("auto_cleared_present", resp_present, 0);

      do_reset;
      issue(1, 32'h4000);
      clr_i = 1'b1;
      req_valid = 1'b1;
      req_op = 1'b0;
      req_addr = 32'h4000;
      #1 check("ext_ready_low", req_ready, 0);
      step;
      clr_i = 1'b0;
      check("ext_busy", busy, 1);
      check("ext_not_accepted", resp_valid, 0);
      for (int i = 0; i < 3; i++) begin
         step;
         check("ext_busy_hold", busy, 1);
         check("ext_no_resp", resp_valid, 0);
      end
      step;
      check("ext_busy_end", busy, 0);
      check("ext_ready_back", req_ready, 1);
      check("ext_count_zero", insert_count, 0);
      step;
      req_valid = 1'b0;
      check("ext_accepted", resp_valid, 1);
      check("ext_present", resp_present, 0);

      do_reset;
      issue(1, 32'h1000);
      issue(0, 32'h1000);
      check("rc_pre_present", resp_present, 1);
      clr_i = 1'b1;
      step;
      clr_i = 1'b0;
      step;
      check("rc_busy_c2", busy, 1);
      #2 rst_n = 1'b0;
      #1;
      check("rc_busy", busy, 0);
      check("rc_present", resp_present, 0);
      check("rc_prio", resp_priority, 0);
      check("rc_valid", resp_valid, 0);
      check("rc_count", insert_count, 0);
      step;
      rst_n = 1'b1;
      issue(0, 32'h1000);
      check("rc_test_valid", resp_valid, 1);
      check("rc_test_present", resp_present, 0);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end
endmodule
